io_bus_responder: RTL

IO_BUS_RESPONDER -- requirements
Module: io_bus_responder

---
 rtl/io_pkg.sv | 44 ++++
 rtl/io_fifo.sv | 72 +++++++
 rtl/io_bus_responder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// io_pkg
// Shared definitions for the IO bus responder slice:
//   - register offsets (decoded from addr[3:2])
//   - write-size encodings
//   - FSM state encoding
//   - STATUS register bit positions
//   - size_mask(): byte-lane mask for a given write size
package io_pkg;

  // Register offsets, as seen on addr[3:2]
  localparam logic [1:0] REG_CTRL    = 2'd0;  // 0x0
  localparam logic [1:0] REG_STATUS  = 2'd1;  // 0x4
  localparam logic [1:0] REG_SCRATCH = 2'd2;  // 0x8
  localparam logic [1:0] REG_FIFO    = 2'd3;  // 0xC

  // Write sizes; any other code means a full word
  localparam logic [1:0] WR_BYTE = 2'b00;
  localparam logic [1:0] WR_HALF = 2'b01;

  // STATUS layout: [4:0] count, [5] empty, [6] full, [7] overflow
  localparam int STAT_COUNT_MSB = 4;
  localparam int STAT_EMPTY_BIT = 5;
  localparam int STAT_FULL_BIT  = 6;
  localparam int STAT_OVF_BIT   = 7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  // Bits of the target that a write of the given size replaces.
  function automatic logic [31:0] size_mask(input logic [1:0] sz);
    logic [31:0] m;
    case (sz)
      WR_BYTE: m = 32'h0000_00FF;
      WR_HALF: m = 32'h0000_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/io_fifo.sv
// io_fifo
// Simple synchronous FIFO backed by an inferred RAM with a registered read.
// Ports:
//   clk    - clock
//   reset  - synchronous active-low reset (pointers and count only)
//   push   - write din (ignored when full)
//   pop    - advance read pointer (ignored when empty)
//   din    - write data
//   dout   - mem[rd_ptr] as sampled on the previous clock edge
//   count  - number of stored entries (0..DEPTH)
//   empty  - count == 0
//   full   - count == DEPTH
module io_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [WIDTH-1:0] dout_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == FULL_COUNT);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // RAM port: no reset so it maps onto block RAM. The read is registered,
  // so dout lags rd_ptr by one cycle; the responder only consumes it after
  // at least one WAIT cycle in which pointers and memory are stable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
    dout_reg <= mem[rd_ptr_reg];
  end

  assign dout  = dout_reg;
  assign count = count_reg;

endmodule

// File: rtl/io_bus_responder.sv
// io_bus_responder
// Fixed-latency memory-mapped responder with four registers
// (CTRL, STATUS, SCRATCH, FIFO) and a level interrupt.
// Ports:
//   clk      - clock
//   reset    - synchronous active-low reset
//   en       - request select from the bus decoder
//   rd_wr    - 1 = write, 0 = read
//   addr     - bus address, only [3:2] decoded
//   wr_size  - 00 byte, 01 half, 10/11 word
//   data_in  - write data
//   data_out - read data, non-zero only in the ready cycle of a read
//   data_oe  - bus drive enable, high only in the ready cycle of a read
//   ready    - one-cycle completion pulse, LATENCY+1 cycles after acceptance
//   irq      - CTRL[1] and FIFO not empty
module io_bus_responder
  import io_pkg::*;
#(
  parameter int LATENCY    = 3,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        rd_wr,
  input  logic [31:0] addr,
  input  logic [1:0]  wr_size,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_oe,
  output logic        ready,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;

  // Request captured at acceptance
  logic        rd_wr_reg;
  logic [1:0]  sel_reg;
  logic [1:0]  wr_size_reg;
  logic [31:0] wdata_reg;

  // Architectural registers
  logic [1:0]  ctrl_reg;
  logic [31:0] scratch_reg;
  logic        ovf_reg;

  // FIFO interface
  logic          fifo_push;
  logic          fifo_pop;
  logic [31:0]   fifo_din;
  logic [31:0]   fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;

  logic        resp;
  logic        accept;
  logic [31:0] wr_mask;
  logic [31:0] status_word;
  logic [31:0] rdata;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{addr[31:4], addr[1:0]};

  assign resp    = (state_reg == S_RESP);
  assign accept  = (state_reg == S_IDLE) && en;
  assign wr_mask = size_mask(wr_size_reg);

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (en) begin
          state_next = S_WAIT;
          cnt_next   = 4'(LATENCY - 1);
        end
      end
      S_WAIT: begin
        if (cnt_reg == 4'd0) state_next = S_RESP;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      S_RESP:  state_next = S_HOLD;
      // Wait for the decoder to drop en so a held request is served once.
      S_HOLD:  if (!en) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------- Request capture ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_wr_reg   <= 1'b0;
      sel_reg     <= 2'd0;
      wr_size_reg <= 2'd0;
      wdata_reg   <= 32'd0;
    end else if (accept) begin
      rd_wr_reg   <= rd_wr;
      sel_reg     <= addr[3:2];
      wr_size_reg <= wr_size;
      wdata_reg   <= data_in;
    end
  end

  // ---------------- FIFO ----------------
  // Pushes only while CTRL[0] is set; a push into a full FIFO is dropped
  // here and flagged as overflow below.
  assign fifo_push = resp &  rd_wr_reg & (sel_reg == REG_FIFO) & ctrl_reg[0] & ~fifo_full;
  assign fifo_pop  = resp & ~rd_wr_reg & (sel_reg == REG_FIFO) & ~fifo_empty;
  assign fifo_din  = wdata_reg & wr_mask;

  io_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // ---------------- Register side effects (RESP cycle only) ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_reg    <= 2'd0;
      scratch_reg <= 32'd0;
      ovf_reg     <= 1'b0;
    end else if (resp) begin
      if (rd_wr_reg) begin
        case (sel_reg)
          // Every write size covers bits [1:0], so CTRL always takes them.
          REG_CTRL:    ctrl_reg    <= wdata_reg[1:0];
          REG_SCRATCH: scratch_reg <= (scratch_reg & ~wr_mask) | (wdata_reg & wr_mask);
          REG_FIFO:    if (ctrl_reg[0] && fifo_full) ovf_reg <= 1'b1;
          default:     ;  // STATUS is read-only
        endcase
      end else if (sel_reg == REG_STATUS) begin
        ovf_reg <= 1'b0;
      end
    end
  end

  // ---------------- Read data ----------------
  always_comb begin
    status_word = 32'd0;
    status_word[STAT_COUNT_MSB:0] = (STAT_COUNT_MSB+1)'(fifo_count);
    status_word[STAT_EMPTY_BIT]   = fifo_empty;
    status_word[STAT_FULL_BIT]    = fifo_full;
    status_word[STAT_OVF_BIT]     = ovf_reg;
  end

  always_comb begin
    rdata = 32'd0;
    case (sel_reg)
      REG_CTRL:    rdata = {30'd0, ctrl_reg};
      REG_STATUS:  rdata = status_word;
      REG_SCRATCH: rdata = scratch_reg;
      REG_FIFO:    rdata = fifo_empty ? 32'd0 : fifo_dout;
      default:     rdata = 32'd0;
    endcase
  end

  // Outputs are gated by reset so they are quiet for the whole reset
  // period, not just after the first reset edge.
  assign ready    = reset & resp;
  assign data_oe  = reset & resp & ~rd_wr_reg;
  assign data_out = data_oe ? rdata : 32'd0;
  assign irq      = reset & ctrl_reg[1] & ~fifo_empty;

endmodule
